// File: rtl/mips_cpu_pkg.sv
// Shared CPU types, plus the data-memory arbiter state and owner encodings.
package mips_cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DM_AW  = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [DM_AW-1:0]  dm_addr_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } dmarb_state_enum;

  typedef enum logic {
    OWNER_CPU,
    OWNER_DBG
  } dmarb_owner_enum;

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational grant for the data-memory arbiter: CPU priority unless debug is starved.
module dm_arb_pick (
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic starve,
  output logic grant_cpu,
  output logic grant_dbg
);

  always_comb begin
    grant_dbg = dbg_req & (starve | ~cpu_req);
    grant_cpu = cpu_req & ~grant_dbg;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter between the CPU mem stage and the debug/loader port.
// One access in flight: IDLE -> ISSUE -> WAIT (DM_LAT cycles) -> RESP.
module dm_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int unsigned DM_LAT         = 1,
  parameter int unsigned DBG_STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  dm_addr_t   cpu_addr,
  input  word_t      cpu_wdata,
  input  logic [3:0] cpu_bytesel,
  output word_t      cpu_rdata,
  output logic       cpu_ack,
  output logic       cpu_stall,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  dm_addr_t   dbg_addr,
  input  word_t      dbg_wdata,
  output word_t      dbg_rdata,
  output logic       dbg_ack,
  output logic       dmce,
  output logic       dmwe,
  output dm_addr_t   dmaddr,
  output word_t      dmdin,
  output logic [3:0] dmbe,
  input  word_t      dmdout
);

  dmarb_state_enum state, state_next;
  dmarb_owner_enum owner_q;
  logic            we_q;
  dm_addr_t        addr_q;
  word_t           wdata_q;
  logic [3:0]      be_q;
  word_t           rd_q;
  logic [3:0]      starve_cnt;
  logic [2:0]      wait_cnt;
  logic            starve;
  logic            grant_cpu, grant_dbg;

  assign starve = (starve_cnt == 4'(DBG_STARVE_MAX));

  dm_arb_pick u_pick (
    .cpu_req  (cpu_req),
    .dbg_req  (dbg_req),
    .starve   (starve),
    .grant_cpu(grant_cpu),
    .grant_dbg(grant_dbg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    dmce       = 1'b0;
    dmwe       = 1'b0;
    dmbe       = '0;
    cpu_ack    = 1'b0;
    dbg_ack    = 1'b0;
    unique case (state)
      IDLE:  if (grant_cpu | grant_dbg) state_next = ISSUE;
      ISSUE: begin
        dmce       = 1'b1;
        dmwe       = we_q;
        dmbe       = be_q;
        state_next = WAIT;
      end
      WAIT:  if (wait_cnt == '0) state_next = RESP;
      RESP: begin
        cpu_ack    = (owner_q == OWNER_CPU);
        dbg_ack    = (owner_q == OWNER_DBG);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    cpu_stall = cpu_req & ~cpu_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWNER_CPU;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= '0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_dbg) begin
            owner_q    <= OWNER_DBG;
            we_q       <= dbg_we;
            addr_q     <= dbg_addr;
            wdata_q    <= dbg_wdata;
            be_q       <= BE_WORD;
            starve_cnt <= '0;
          end else if (grant_cpu) begin
            owner_q <= OWNER_CPU;
            we_q    <= cpu_we;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            be_q    <= cpu_we ? cpu_bytesel : BE_WORD;
            // A CPU grant with debug waiting implies starve is not yet saturated.
            if (!dbg_req)     starve_cnt <= '0;
            else if (!starve) starve_cnt <= starve_cnt + 4'd1;
          end else begin
            starve_cnt <= '0;
          end
        end
        ISSUE: wait_cnt <= 3'(DM_LAT - 1);
        WAIT: begin
          if (wait_cnt == '0) begin
            if (!we_q) rd_q <= dmdout;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmaddr    = addr_q;
  assign dmdin     = wdata_q;
  assign cpu_rdata = rd_q;
  assign dbg_rdata = rd_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: per-port expectation queues filled at request time,
// checked by independent issue and acknowledge monitors against a word-array memory model.
module tb_dm_arbiter;
  import mips_cpu_pkg::*;

  localparam int unsigned STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DM_LAT = 1 instance
  logic       cpu_req = 0, cpu_we = 0, cpu_ack, cpu_stall;
  dm_addr_t   cpu_addr = '0;
  word_t      cpu_wdata = '0, cpu_rdata;
  logic [3:0] cpu_bytesel = 4'hF;
  logic       dbg_req = 0, dbg_we = 0, dbg_ack;
  dm_addr_t   dbg_addr = '0;
  word_t      dbg_wdata = '0, dbg_rdata;
  logic       dmce, dmwe;
  dm_addr_t   dmaddr;
  word_t      dmdin, dmdout;
  logic [3:0] dmbe;

  // DM_LAT = 3 instance
  logic       cpu_req3 = 0, cpu_ack3, cpu_stall3, dbg_ack3;
  dm_addr_t   cpu_addr3 = '0;
  word_t      cpu_rdata3, dbg_rdata3, dmdin3, dmdout3;
  logic       dmce3, dmwe3;
  dm_addr_t   dmaddr3;
  logic [3:0] dmbe3;

  dm_arbiter #(.DM_LAT(1), .DBG_STARVE_MAX(STARVE)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_bytesel(cpu_bytesel), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .dmce(dmce), .dmwe(dmwe), .dmaddr(dmaddr), .dmdin(dmdin), .dmbe(dmbe), .dmdout(dmdout)
  );

  dm_arbiter #(.DM_LAT(3), .DBG_STARVE_MAX(STARVE)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req3), .cpu_we(1'b0), .cpu_addr(cpu_addr3), .cpu_wdata('0),
    .cpu_bytesel(4'hF), .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3), .cpu_stall(cpu_stall3),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr('0), .dbg_wdata('0),
    .dbg_rdata(dbg_rdata3), .dbg_ack(dbg_ack3),
    .dmce(dmce3), .dmwe(dmwe3), .dmaddr(dmaddr3), .dmdin(dmdin3), .dmbe(dmbe3), .dmdout(dmdout3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic note_fail(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s %s", name, what);
  endtask

  function automatic word_t init_word(input int unsigned i);
    return (i == 16) ? 32'hDEADBEEF : (32'h5A000000 | (i * 32'h00010203));
  endfunction

  // Memories: the DUT-facing array is written only through dm* signals;
  // ref_mem is the bench's own view, updated when a request is issued.
  word_t tb_mem [512];
  word_t ref_mem[512];
  bit    mem_ready;
  word_t pipe1;
  word_t p3[3];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int unsigned i = 0; i < 512; i++) tb_mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (dmce && dmwe) begin
      for (int unsigned b = 0; b < 4; b++)
        if (dmbe[b]) tb_mem[dmaddr[10:2]][8*b +: 8] <= dmdin[8*b +: 8];
    end
    pipe1 <= (dmce && !dmwe) ? tb_mem[dmaddr[10:2]] : $urandom;
    p3[0] <= (dmce3 && !dmwe3) ? (32'hC0FFEE00 ^ dmaddr3) : $urandom;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign dmdout  = pipe1;
  assign dmdout3 = p3[2];

  typedef struct {
    logic       we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] be;
    logic [31:0] rd;
  } exp_t;

  exp_t cpu_iss_q[$], dbg_iss_q[$], cpu_ack_q[$], dbg_ack_q[$];

  function automatic exp_t model_access(input bit dbg, input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] bsel);
    exp_t e;
    int unsigned idx;
    idx     = int'(addr[10:2]);
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.be    = (!dbg && we) ? bsel : 4'hF;
    if (we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (e.be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    e.rd = ref_mem[idx];
    return e;
  endfunction

  // Issue monitor: every dmce cycle must match the oldest pending request of its port.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dmce) begin
      if (dmaddr[8] ? (dbg_iss_q.size() == 0) : (cpu_iss_q.size() == 0)) begin
        note_fail("issue_unexpected", $sformatf("actual addr=%h required=none", dmaddr));
      end else begin
        e = dmaddr[8] ? dbg_iss_q.pop_front() : cpu_iss_q.pop_front();
        chk("issue_addr", dmaddr, e.addr);
        chk("issue_we", 32'(dmwe), 32'(e.we));
        chk("issue_be", 32'(dmbe), 32'(e.be));
        if (e.we) chk("issue_wdata", dmdin, e.wdata);
      end
    end
  end

  // Acknowledge monitor: pops the port queue and checks load data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (cpu_ack && dbg_ack) note_fail("dual_ack", "actual=both required=one");
      if (cpu_ack) begin
        if (cpu_ack_q.size() == 0) note_fail("cpu_ack_unexpected", "actual=ack required=none");
        else begin
          e = cpu_ack_q.pop_front();
          if (!e.we) chk("cpu_rdata", cpu_rdata, e.rd);
        end
      end
      if (dbg_ack) begin
        if (dbg_ack_q.size() == 0) note_fail("dbg_ack_unexpected", "actual=ack required=none");
        else begin
          e = dbg_ack_q.pop_front();
          if (!e.we) chk("dbg_rdata", dbg_rdata, e.rd);
        end
      end
    end
  end

  task automatic cpu_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] bsel, input int drop_at, output int lat);
    exp_t e;
    int n;
    bit got;
    e = model_access(1'b0, we, addr, wdata, bsel);
    cpu_iss_q.push_back(e);
    cpu_ack_q.push_back(e);
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_bytesel = bsel;
    n = 0; got = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (n == drop_at) cpu_req = 0;
      if (cpu_ack) got = 1;
      else n++;
    end
    if (!got) note_fail("cpu_ack_timeout", "actual=no_ack required=ack");
    lat = n;
    @(posedge clk); #1;
    cpu_req = 0;
  endtask

  task automatic dbg_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int n;
    bit got;
    e = model_access(1'b1, we, addr, wdata, 4'hF);
    dbg_iss_q.push_back(e);
    dbg_ack_q.push_back(e);
    @(posedge clk); #1;
    dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    n = 0; got = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (dbg_ack) got = 1;
      else n++;
    end
    if (!got) note_fail("dbg_ack_timeout", "actual=no_ack required=ack");
    @(posedge clk); #1;
    dbg_req = 0;
  endtask

  function automatic logic [3:0] pick_be(input int unsigned r);
    case (r)
      0:       return 4'b1111;
      1:       return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  initial begin
    int lat, n, k, acks, run, cyc, last, dce_cyc;
    bit got;
    bit seq[10];
    exp_t e;
    logic [31:0] exp34[4];

    for (int unsigned i = 0; i < 512; i++) ref_mem[i] = init_word(i);

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("reset_ctrl", 32'({dmce, dmwe, dmbe, cpu_ack, dbg_ack, cpu_stall}), 32'h0);
    chk("reset_dmaddr", dmaddr, 32'h0);
    chk("reset_dmdin", dmdin, 32'h0);
    chk("reset_rdata", cpu_rdata | dbg_rdata, 32'h0);
    chk("reset_ctrl3", 32'({dmce3, dmwe3, dmbe3, cpu_ack3, cpu_rdata3 != 0}), 32'h0);
    @(posedge clk); #1 rst = 0;

    // Single CPU load, cycle-by-cycle {dmce, cpu_ack, cpu_stall}
    exp34 = '{32'h1, 32'h5, 32'h1, 32'h2};
    fork
      cpu_xfer(1'b0, 32'h40, 32'h0, 4'hF, -1, lat);
      begin
        @(posedge clk);
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk($sformatf("load_cycle%0d", c), 32'({dmce, cpu_ack, cpu_stall}), exp34[c]);
        end
      end
    join
    chk("load_latency", 32'(lat), 32'd3);

    // Byte store, debug load, readback of partial store, read register hold across a store
    cpu_xfer(1'b1, 32'h44, 32'h000000AB, 4'b0001, -1, lat);
    dbg_xfer(1'b0, 32'h104, 32'h0);
    cpu_xfer(1'b0, 32'h44, 32'h0, 4'hF, -1, lat);
    cpu_xfer(1'b1, 32'h48, 32'h12345678, 4'b0011, -1, lat);
    cpu_xfer(1'b0, 32'h40, 32'h0, 4'hF, -1, lat);
    cpu_xfer(1'b1, 32'h4C, 32'hCAFEF00D, 4'b1111, -1, lat);
    chk("rdata_hold_store", cpu_rdata, 32'hDEADBEEF);

    // Request dropped during ISSUE still completes
    cpu_xfer(1'b0, 32'h48, 32'h0, 4'hF, 1, lat);
    chk("drop_latency", 32'(lat), 32'd3);

    // Both ports held: debug wins after STARVE consecutive CPU grants
    run = 0;
    for (int i = 0; i < 10; i++) begin
      if (run == int'(STARVE)) begin seq[i] = 1; run = 0; end
      else begin seq[i] = 0; run++; end
      e = model_access(seq[i], 1'b0, seq[i] ? 32'h104 : 32'h40, 32'h0, 4'hF);
      if (seq[i]) begin dbg_iss_q.push_back(e); dbg_ack_q.push_back(e); end
      else begin cpu_iss_q.push_back(e); cpu_ack_q.push_back(e); end
    end
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h104;
    cyc = 0; last = 0;
    for (int i = 0; i < 10; i++) begin
      got = 0; k = 0;
      while (!got && k < 50) begin
        @(negedge clk);
        cyc++;
        if (cpu_ack || dbg_ack) got = 1;
        else k++;
      end
      if (!got) begin
        note_fail("grant_timeout", "actual=no_ack required=ack");
        break;
      end
      chk($sformatf("grant_order%0d", i), 32'(dbg_ack), 32'(seq[i]));
      if (i > 0) chk("throughput", 32'(cyc - last), 32'd4);
      last = cyc;
    end
    @(posedge clk); #1;
    cpu_req = 0; dbg_req = 0;

    // DM_LAT = 3 instance: ack after 5 cycles, dmce in cycle 1
    @(posedge clk); #1;
    cpu_req3 = 1; cpu_addr3 = 32'h40;
    n = 0; got = 0; dce_cyc = -1;
    while (!got && n < 50) begin
      @(negedge clk);
      if (dmce3 && dce_cyc < 0) dce_cyc = n;
      if (cpu_ack3) got = 1;
      else n++;
    end
    chk("lat3_ack", 32'(n), 32'd5);
    chk("lat3_dmce", 32'(dce_cyc), 32'd1);
    chk("lat3_rdata", cpu_rdata3, 32'hC0FFEE40);
    @(posedge clk); #1 cpu_req3 = 0;

    // Reset in WAIT abandons the access
    e = model_access(1'b0, 1'b0, 32'h50, 32'h0, 4'hF);
    cpu_iss_q.push_back(e);
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
    rst = 1; cpu_req = 0;
    #1;
    chk("rst_async_rdata", cpu_rdata, 32'h0);
    chk("rst_async_ctrl", 32'({dmce, dmwe, dmbe, cpu_ack, dbg_ack, cpu_stall}), 32'h0);
    chk("rst_async_dmaddr", dmaddr, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) acks++;
    end
    chk("no_ack_after_reset", 32'(acks), 32'd0);
    cpu_xfer(1'b0, 32'h50, 32'h0, 4'hF, -1, lat);
    chk("reissue_latency", 32'(lat), 32'd3);

    // Randomized traffic on both ports, disjoint address regions
    fork
      begin
        logic       cw;
        logic [3:0] cb;
        int         cl;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          cw = 1'($urandom_range(0, 1));
          cb = pick_be($urandom_range(0, 2));
          cpu_xfer(cw, 32'($urandom_range(0, 63)) << 2, $urandom, cb, -1, cl);
        end
      end
      begin
        logic dw;
        for (int i = 0; i < 25; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          dw = 1'($urandom_range(0, 1));
          dbg_xfer(dw, 32'h100 | (32'($urandom_range(0, 63)) << 2), $urandom);
        end
      end
    join

    repeat (5) @(negedge clk);
    chk("cpu_queue_drained", 32'(cpu_ack_q.size() + cpu_iss_q.size()), 32'd0);
    chk("dbg_queue_drained", 32'(dbg_ack_q.size() + dbg_iss_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
